// File: rtl/cpu_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_bridge_pkg
//  Description : Shared types and helpers for the CPU-side memory bridge.
//                - bridgeState_t : request FSM states (IDLE / WAIT / RSP)
//                - timeoutData() : all-ones word of a given width, returned
//                                  as read data when a request times out
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_bridge_pkg;

  // Request FSM states. IDLE accepts a command, WAIT holds the level request
  // to the controller, RSP presents the response to the host.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } bridgeState_t;

  // Widest data word timeoutData() can describe.
  localparam int MAX_DATA_WIDTH = 64;

  // All-ones pattern in the low 'width' bits; callers truncate to their own
  // data width. Built bit by bit so it stays valid for width == MAX_DATA_WIDTH.
  function automatic logic [MAX_DATA_WIDTH-1:0] timeoutData(input int width);
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < width) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage : cpu_mem_bridge_pkg
`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_bridge
//  Description : Host valid/ready command/response channel to the level-held,
//                edge-detected cpuMemReq port of the single-port memory
//                controller. One outstanding command. All request fields are
//                held stable from the cycle after acceptance until cpuMemAck.
//                A saturating timer bounds the wait for an ack.
//
//  Ports
//    clockCore, resetCore            : clock, async active-high reset
//    hostCmdValid/Ready/Rd/Addr/WrData : host command channel
//    hostRspValid/Ready/RdData/Err   : host response channel
//                                      (RdData = 0 for writes, all-ones and
//                                      Err = 1 on timeout)
//    cpuMemReq/Rd/Addr/WrData        : request to controller (registered)
//    cpuMemAck, cpuMemRdData         : ack pulse and read data from controller
//    strayAck                        : sticky, ack seen while not waiting
//    busy                            : bridge not in IDLE
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clockCore,
  input  logic                  resetCore,

  input  logic                  hostCmdValid,
  output logic                  hostCmdReady,
  input  logic                  hostCmdRd,
  input  logic [ADDR_WIDTH-1:0] hostCmdAddr,
  input  logic [DATA_WIDTH-1:0] hostCmdWrData,

  output logic                  hostRspValid,
  input  logic                  hostRspReady,
  output logic [DATA_WIDTH-1:0] hostRspRdData,
  output logic                  hostRspErr,

  output logic                  cpuMemReq,
  output logic                  cpuMemRd,
  output logic [ADDR_WIDTH-1:0] cpuMemAddr,
  output logic [DATA_WIDTH-1:0] cpuMemWrData,
  input  logic                  cpuMemAck,
  input  logic [DATA_WIDTH-1:0] cpuMemRdData,

  output logic                  strayAck,
  output logic                  busy
);

  localparam int                    TIMER_WIDTH  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0]  TIMEOUT_DATA = DATA_WIDTH'(timeoutData(DATA_WIDTH));

  bridgeState_t           r_state;
  bridgeState_t           w_stateNext;
  logic [TIMER_WIDTH-1:0] r_timer;

  logic w_accept;     // command handshake completes this cycle
  logic w_ackTaken;   // ack consumed in WAIT
  logic w_timedOut;   // WAIT expired without ack

  // The only combinational output: ready is a pure decode of the state.
  assign hostCmdReady = (r_state == IDLE);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_ackTaken  = 1'b0;
    w_timedOut  = 1'b0;
    case (r_state)
      IDLE: begin
        if (hostCmdValid) begin
          w_accept    = 1'b1;
          w_stateNext = WAIT;
        end
      end
      WAIT: begin
        // Ack is checked first so an ack landing on the last timer cycle
        // still completes the access normally.
        if (cpuMemAck) begin
          w_ackTaken  = 1'b1;
          w_stateNext = RSP;
        end else if (r_timer == TIMER_LAST) begin
          w_timedOut  = 1'b1;
          w_stateNext = RSP;
        end
      end
      RSP: begin
        if (hostRspReady) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Controller request fields. Loaded only on acceptance, so they cannot move
  // while WAIT holds cpuMemReq high (the controller samples rd/addr a cycle
  // late and uses wrData combinationally at grant).
  // --------------------------------------------------------------------------
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      cpuMemReq    <= 1'b0;
      cpuMemRd     <= 1'b0;
      cpuMemAddr   <= '0;
      cpuMemWrData <= '0;
    end else begin
      cpuMemReq <= (w_stateNext == WAIT);
      if (w_accept) begin
        cpuMemRd     <= hostCmdRd;
        cpuMemAddr   <= hostCmdAddr;
        cpuMemWrData <= hostCmdWrData;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Wait timer: cleared on acceptance, counts WAIT cycles, saturates at the
  // timeout value so it never wraps.
  // --------------------------------------------------------------------------
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      r_timer <= '0;
    end else if (w_accept) begin
      r_timer <= '0;
    end else if ((r_state == WAIT) && (r_timer != TIMER_LAST)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Response channel. Fields are written only when leaving WAIT, so they stay
  // stable for the whole RSP phase regardless of hostRspReady.
  // --------------------------------------------------------------------------
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      hostRspValid  <= 1'b0;
      hostRspRdData <= '0;
      hostRspErr    <= 1'b0;
    end else begin
      hostRspValid <= (w_stateNext == RSP);
      if (w_ackTaken) begin
        hostRspRdData <= cpuMemRd ? cpuMemRdData : '0;
        hostRspErr    <= 1'b0;
      end else if (w_timedOut) begin
        hostRspRdData <= TIMEOUT_DATA;
        hostRspErr    <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status. An ack outside WAIT (typically a late ack after a timeout) carries
  // no usable data; it is only flagged.
  // --------------------------------------------------------------------------
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      busy     <= 1'b0;
      strayAck <= 1'b0;
    end else begin
      busy <= (w_stateNext != IDLE);
      if (cpuMemAck && (r_state != WAIT)) begin
        strayAck <= 1'b1;
      end
    end
  end

endmodule : cpu_mem_bridge
`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mem_bridge
//  Description : Self-checking bench for cpu_mem_bridge. A fake controller
//                acks requests after a fixed latency (plus optional extra
//                contention cycles, or never). A transaction-level model
//                predicts, per accepted command, how long cpuMemReq stays high
//                and what the response must be; one compare process checks
//                every cycle against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_bridge;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TC = 16;

  logic          clockCore = 1'b0;
  logic          resetCore = 1'b1;
  logic          hostCmdValid = 1'b0;
  logic          hostCmdReady;
  logic          hostCmdRd = 1'b0;
  logic [AW-1:0] hostCmdAddr = '0;
  logic [DW-1:0] hostCmdWrData = '0;
  logic          hostRspValid;
  logic          hostRspReady = 1'b1;
  logic [DW-1:0] hostRspRdData;
  logic          hostRspErr;
  logic          cpuMemReq;
  logic          cpuMemRd;
  logic [AW-1:0] cpuMemAddr;
  logic [DW-1:0] cpuMemWrData;
  logic          cpuMemAck;
  logic [DW-1:0] cpuMemRdData = 16'hDEAD;
  logic          strayAck;
  logic          busy;

  logic ctrlAck = 1'b0;
  logic injAck  = 1'b0;
  assign cpuMemAck = ctrlAck | injAck;

  cpu_mem_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clockCore    (clockCore),
    .resetCore    (resetCore),
    .hostCmdValid (hostCmdValid),
    .hostCmdReady (hostCmdReady),
    .hostCmdRd    (hostCmdRd),
    .hostCmdAddr  (hostCmdAddr),
    .hostCmdWrData(hostCmdWrData),
    .hostRspValid (hostRspValid),
    .hostRspReady (hostRspReady),
    .hostRspRdData(hostRspRdData),
    .hostRspErr   (hostRspErr),
    .cpuMemReq    (cpuMemReq),
    .cpuMemRd     (cpuMemRd),
    .cpuMemAddr   (cpuMemAddr),
    .cpuMemWrData (cpuMemWrData),
    .cpuMemAck    (cpuMemAck),
    .cpuMemRdData (cpuMemRdData),
    .strayAck     (strayAck),
    .busy         (busy)
  );

  always #5 clockCore = ~clockCore;

  int cyc = 0;
  always @(posedge clockCore) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Fake controller: acks (rd ? 6 : 5) + ctrlExtra cycles after the first
  // cycle it sees cpuMemReq high, i.e. write ack at T+5, read ack at T+6.
  // --------------------------------------------------------------------------
  logic [DW-1:0] ctrlMem [256];
  int            ctrlCnt      = 0;
  logic          ctrlDone     = 1'b0;
  logic          ctrlSuppress = 1'b0;
  int            ctrlExtra    = 0;

  always @(negedge clockCore) begin
    ctrlAck = 1'b0;
    if (!cpuMemReq) begin
      ctrlCnt  = 0;
      ctrlDone = 1'b0;
    end else if (!ctrlDone) begin
      ctrlCnt++;
      if (!ctrlSuppress && (ctrlCnt == (cpuMemRd ? 6 : 5) + ctrlExtra)) begin
        ctrlAck  = 1'b1;
        ctrlDone = 1'b1;
        if (cpuMemRd) begin
          cpuMemRdData = ctrlMem[cpuMemAddr];
        end else begin
          ctrlMem[cpuMemAddr] = cpuMemWrData;
          cpuMemRdData        = 16'hDEAD;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction model
  // --------------------------------------------------------------------------
  typedef struct {
    int            e;        // first cycle cpuMemReq must be high (T+1)
    int            reqLen;   // cycles cpuMemReq stays high
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] expData;
    logic          expErr;
  } item_t;

  item_t         q[$];
  logic [DW-1:0] refMem [256];
  int            strayCyc    = 32'h7fffffff;
  int            lastAcceptE = 0;

  int            reqLowRun   = 100;
  int            reqHighRun  = 0;
  int            lastReqLen  = 0;
  int            rspRiseCyc  = 0;
  logic          prevReq     = 1'b0;
  logic          prevRspV    = 1'b0;
  logic          seenReq     = 1'b0;
  logic [DW-1:0] lastRspData = '0;
  logic          lastRspErr  = 1'b0;

  always @(negedge clockCore) begin : cmpProc
    logic active;
    logic expReq;
    logic expRv;
    if (resetCore) begin
      check("rst_cmd_ready", 32'(hostCmdReady), 32'd1);
      check("rst_mem_req",   32'(cpuMemReq),    32'd0);
      check("rst_mem_rd",    32'(cpuMemRd),     32'd0);
      check("rst_mem_addr",  32'(cpuMemAddr),   32'd0);
      check("rst_mem_wd",    32'(cpuMemWrData), 32'd0);
      check("rst_rsp_valid", 32'(hostRspValid), 32'd0);
      check("rst_rsp_data",  32'(hostRspRdData), 32'd0);
      check("rst_rsp_err",   32'(hostRspErr),   32'd0);
      check("rst_stray",     32'(strayAck),     32'd0);
      check("rst_busy",      32'(busy),         32'd0);
    end else begin
      active = (q.size() > 0) && (cyc >= q[0].e);
      expReq = active && (cyc < q[0].e + q[0].reqLen);
      expRv  = active && !expReq;
      check("cmd_ready", 32'(hostCmdReady), 32'(!active));
      check("busy",      32'(busy),         32'(active));
      check("mem_req",   32'(cpuMemReq),    32'(expReq));
      check("rsp_valid", 32'(hostRspValid), 32'(expRv));
      check("stray_ack", 32'(strayAck),     32'(cyc >= strayCyc));
      if (expReq) begin
        check("mem_rd",   32'(cpuMemRd),     32'(q[0].rd));
        check("mem_addr", 32'(cpuMemAddr),   32'(q[0].addr));
        check("mem_wd",   32'(cpuMemWrData), 32'(q[0].wd));
      end
      if (expRv) begin
        check("rsp_data", 32'(hostRspRdData), 32'(q[0].expData));
        check("rsp_err",  32'(hostRspErr),    32'(q[0].expErr));
        if (hostRspReady) begin
          lastRspData = hostRspRdData;
          lastRspErr  = hostRspErr;
          void'(q.pop_front());
        end
      end
    end
    // Request pulse bookkeeping for gap and length checks.
    if (cpuMemReq) begin
      if (!prevReq) begin
        if (seenReq) check("req_low_gap", 32'(reqLowRun >= 2), 32'd1);
        seenReq    = 1'b1;
        reqHighRun = 0;
      end
      reqHighRun++;
      reqLowRun = 0;
    end else begin
      if (prevReq) lastReqLen = reqHighRun;
      reqLowRun++;
    end
    if (hostRspValid && !prevRspV) rspRiseCyc = cyc;
    prevReq  = cpuMemReq;
    prevRspV = hostRspValid;
  end

  // --------------------------------------------------------------------------
  // Driver tasks (called on the falling edge, return on a falling edge)
  // --------------------------------------------------------------------------
  task automatic sendCmd(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int extra, input logic suppress);
    item_t it;
    int    lat;
    int    tries;
    logic  done;
    tries     = 0;
    done      = 1'b0;
    lat       = (rd ? 6 : 5) + extra;
    it.rd     = rd;
    it.addr   = addr;
    it.wd     = wd;
    if (suppress || (lat > TC)) begin
      it.reqLen  = TC;
      it.expData = 16'hFFFF;
      it.expErr  = 1'b1;
    end else begin
      it.reqLen  = lat;
      it.expData = rd ? refMem[addr] : 16'h0000;
      it.expErr  = 1'b0;
      if (!rd) refMem[addr] = wd;
    end
    hostCmdValid  = 1'b1;
    hostCmdRd     = rd;
    hostCmdAddr   = addr;
    hostCmdWrData = wd;
    while (!done) begin
      if (hostCmdReady) begin
        it.e         = cyc + 1;
        ctrlExtra    = extra;
        ctrlSuppress = suppress;
        lastAcceptE  = it.e;
        q.push_back(it);
        done = 1'b1;
      end else if (tries > 200) begin
        check("cmd_accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      tries++;
      @(negedge clockCore);
    end
    hostCmdValid = 1'b0;
  endtask

  task automatic waitIdle();
    int tries;
    tries = 0;
    while ((q.size() != 0) && (tries < 300)) begin
      tries++;
      @(negedge clockCore);
    end
    if (q.size() != 0) begin
      check("rsp_wait_timeout", 32'd0, 32'd1);
      q.delete();
    end
    @(negedge clockCore);
  endtask

  task automatic setRspReady(input logic v);
    @(posedge clockCore);
    #2 hostRspReady = v;
    @(negedge clockCore);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ctrlMem[i] = '0;
      refMem[i]  = '0;
    end
    repeat (3) @(negedge clockCore);
    @(posedge clockCore);
    #2 resetCore = 1'b0;
    @(negedge clockCore);

    // Write 0x12 <- 0xBEEF, uncontended.
    sendCmd(1'b0, 8'h12, 16'hBEEF, 0, 1'b0);
    waitIdle();
    check("w12_req_len",  32'(lastReqLen), 32'd5);
    check("w12_rsp_lat",  32'(rspRiseCyc - lastAcceptE), 32'd5);
    check("w12_rsp_data", 32'(lastRspData), 32'h0000);
    check("w12_rsp_err",  32'(lastRspErr), 32'd0);

    // Read it back, uncontended.
    sendCmd(1'b1, 8'h12, 16'h0000, 0, 1'b0);
    waitIdle();
    check("r12_req_len",  32'(lastReqLen), 32'd6);
    check("r12_rsp_lat",  32'(rspRiseCyc - lastAcceptE), 32'd6);
    check("r12_rsp_data", 32'(lastRspData), 32'hBEEF);

    // Contended reads: 3 extra cycles, then 10 (ack on the final timer cycle).
    sendCmd(1'b0, 8'h34, 16'h1234, 0, 1'b0);
    sendCmd(1'b1, 8'h34, 16'h5A5A, 3, 1'b0);
    waitIdle();
    check("r34c3_req_len",  32'(lastReqLen), 32'd9);
    check("r34c3_rsp_data", 32'(lastRspData), 32'h1234);
    sendCmd(1'b1, 8'h34, 16'hC3C3, 10, 1'b0);
    waitIdle();
    check("r34c10_req_len",  32'(lastReqLen), 32'd16);
    check("r34c10_rsp_data", 32'(lastRspData), 32'h1234);
    check("r34c10_rsp_err",  32'(lastRspErr), 32'd0);

    // Ack suppressed: timeout, then a late ack.
    sendCmd(1'b1, 8'h12, 16'h0000, 0, 1'b1);
    waitIdle();
    check("to_req_len",  32'(lastReqLen), 32'd16);
    check("to_rsp_lat",  32'(rspRiseCyc - lastAcceptE), 32'd16);
    check("to_rsp_data", 32'(lastRspData), 32'hFFFF);
    check("to_rsp_err",  32'(lastRspErr), 32'd1);
    injAck   = 1'b1;
    strayCyc = cyc + 1;
    @(negedge clockCore);
    injAck = 1'b0;
    @(negedge clockCore);
    check("late_ack_stray", 32'(strayAck), 32'd1);

    // Contention one cycle past the timeout also times out.
    sendCmd(1'b1, 8'h34, 16'h0000, 11, 1'b0);
    waitIdle();
    check("to11_rsp_err", 32'(lastRspErr), 32'd1);

    // Response back-pressure followed by back-to-back commands.
    setRspReady(1'b0);
    sendCmd(1'b0, 8'h56, 16'hA5A5, 0, 1'b0);
    fork
      begin
        repeat (12) @(negedge clockCore);
        setRspReady(1'b1);
      end
      sendCmd(1'b1, 8'h56, 16'h0000, 0, 1'b0);
    join
    sendCmd(1'b0, 8'h57, 16'h0F0F, 0, 1'b0);
    sendCmd(1'b1, 8'h57, 16'h0000, 0, 1'b0);
    waitIdle();
    check("b2b_rsp_data", 32'(lastRspData), 32'h0F0F);

    // Reset while waiting for the controller; ack during reset is ignored.
    sendCmd(1'b1, 8'h12, 16'h0000, 0, 1'b0);
    @(negedge clockCore);
    @(posedge clockCore);
    #2 resetCore = 1'b1;
    q.delete();
    strayCyc = 32'h7fffffff;
    @(negedge clockCore);
    injAck = 1'b1;
    @(negedge clockCore);
    injAck = 1'b0;
    @(posedge clockCore);
    #2 resetCore = 1'b0;
    @(negedge clockCore);
    check("post_rst_stray", 32'(strayAck), 32'd0);

    // Normal read after reset.
    sendCmd(1'b1, 8'h12, 16'h0000, 0, 1'b0);
    waitIdle();
    check("post_rst_rsp_data", 32'(lastRspData), 32'hBEEF);
    check("post_rst_rsp_lat",  32'(rspRiseCyc - lastAcceptE), 32'd6);

    repeat (3) @(negedge clockCore);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cpu_mem_bridge
`default_nettype wire
